// File: rtl/vdp_super_high_res_writer_if.sv
// Pixel-stream and VRAM write-port signals of the super high-res writer.
// master = the writer, slave = pixel source / VRAM arbiter.
interface vdp_super_high_res_writer_if;
  logic        pix_valid;
  logic        pix_ready;
  logic [23:0] pix_rgb;
  logic        vram_wr_req;
  logic [16:0] vram_wr_addr;
  logic [31:0] vram_wr_data;
  logic        vram_wr_ack;

  modport master (
    input  pix_valid, pix_rgb, vram_wr_ack,
    output pix_ready, vram_wr_req, vram_wr_addr, vram_wr_data
  );

  modport slave (
    output pix_valid, pix_rgb, vram_wr_ack,
    input  pix_ready, vram_wr_req, vram_wr_addr, vram_wr_data
  );
endinterface

// File: rtl/vdp_super_high_res_writer.sv
// Writes a 180xHEIGHT RGB frame into VRAM at stride 2 for the super high-res reader.
// SUPER_HIGH_RES_WRITER_FIFO_EN selects a 4-entry FIFO; otherwise a single holding register.
module vdp_super_high_res_writer (
  input  logic       clk,
  input  logic       reset,
  input  logic       super_high_res,
  input  logic       pal_mode,
  input  logic       set_xy,
  input  logic [7:0] set_x,
  input  logic [7:0] set_y,
  vdp_super_high_res_writer_if.master bus,
  output logic       busy,
  output logic       coord_err
);

  typedef struct packed {
    logic [16:0] addr;
    logic [23:0] rgb;
  } wr_ent_t;

  typedef enum logic {IDLE = 1'b0, REQ = 1'b1} state_t;

  state_t      state_q, state_d;
  logic [7:0]  x_q, x_d, y_q, y_d;
  logic [16:0] addr_q, addr_d;
  logic        coord_err_q, coord_err_d;
  logic [16:0] wr_addr_q, wr_addr_d;
  logic [23:0] wr_rgb_q, wr_rgb_d;

  logic [7:0]  height;
  logic [15:0] set_lin;
  logic        set_ok, load;
  logic        accept, push, pop;
  logic        has_entry, room;
  wr_ent_t     head, push_ent;

  assign height   = pal_mode ? 8'd144 : 8'd120;
  assign set_lin  = 16'(set_y) * 16'd180 + 16'(set_x);
  assign set_ok   = (set_x < 8'd180) && (set_y < height);
  assign load     = set_xy && super_high_res;

  assign pop      = super_high_res && (state_q == IDLE) && has_entry;
  assign bus.pix_ready = !reset && super_high_res && !set_xy && room;
  assign accept   = bus.pix_valid && bus.pix_ready;
  // After a bad set_xy pixels are still drained from the source, just not stored.
  assign push     = accept && !coord_err_q;
  assign push_ent = '{addr: addr_q, rgb: bus.pix_rgb};

`ifdef SUPER_HIGH_RES_WRITER_FIFO_EN
  wr_ent_t [3:0] fifo_q, fifo_d;
  logic [1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [2:0]    count_q, count_d;

  assign has_entry = (count_q != 3'd0);
  // A full FIFO still takes a pixel in the cycle its head is popped.
  assign room      = (count_q != 3'd4) || pop;
  assign head      = fifo_q[rd_ptr_q];

  always_comb begin
    fifo_d   = fifo_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (!super_high_res) begin
      wr_ptr_d = 2'd0;
      rd_ptr_d = 2'd0;
      count_d  = 3'd0;
    end else begin
      if (push) begin
        fifo_d[wr_ptr_q] = push_ent;
        wr_ptr_d         = wr_ptr_q + 2'd1;
      end
      if (pop) rd_ptr_d = rd_ptr_q + 2'd1;
      count_d = count_q + 3'(push) - 3'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fifo_q   <= '0;
      wr_ptr_q <= 2'd0;
      rd_ptr_q <= 2'd0;
      count_q  <= 3'd0;
    end else begin
      fifo_q   <= fifo_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end
`else
  wr_ent_t ent_q, ent_d;
  logic    ent_vld_q, ent_vld_d;

  assign has_entry = ent_vld_q;
  assign room      = !ent_vld_q && (state_q == IDLE);
  assign head      = ent_q;

  always_comb begin
    ent_d     = ent_q;
    ent_vld_d = ent_vld_q;
    if (!super_high_res) begin
      ent_vld_d = 1'b0;
    end else begin
      if (pop) ent_vld_d = 1'b0;
      if (push) begin
        ent_d     = push_ent;
        ent_vld_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ent_q     <= '0;
      ent_vld_q <= 1'b0;
    end else begin
      ent_q     <= ent_d;
      ent_vld_q <= ent_vld_d;
    end
  end
`endif

  // Write pointer: raster order, wrapping to the frame origin after the last pixel.
  always_comb begin
    x_d         = x_q;
    y_d         = y_q;
    addr_d      = addr_q;
    coord_err_d = coord_err_q;
    if (load) begin
      if (set_ok) begin
        x_d         = set_x;
        y_d         = set_y;
        addr_d      = {set_lin, 1'b0};
        coord_err_d = 1'b0;
      end else begin
        x_d         = 8'd0;
        y_d         = 8'd0;
        addr_d      = 17'd0;
        coord_err_d = 1'b1;
      end
    end else if (accept) begin
      if (x_q == 8'd179) begin
        x_d = 8'd0;
        if (y_q >= height - 8'd1) begin
          y_d    = 8'd0;
          addr_d = 17'd0;
        end else begin
          y_d    = y_q + 8'd1;
          addr_d = addr_q + 17'd2;
        end
      end else begin
        x_d    = x_q + 8'd1;
        addr_d = addr_q + 17'd2;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    wr_addr_d = wr_addr_q;
    wr_rgb_d  = wr_rgb_q;
    case (state_q)
      IDLE: if (pop) begin
        state_d   = REQ;
        wr_addr_d = head.addr;
        wr_rgb_d  = head.rgb;
      end
      REQ:  if (bus.vram_wr_ack) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      x_q         <= 8'd0;
      y_q         <= 8'd0;
      addr_q      <= 17'd0;
      coord_err_q <= 1'b0;
      wr_addr_q   <= 17'd0;
      wr_rgb_q    <= 24'd0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      addr_q      <= addr_d;
      coord_err_q <= coord_err_d;
      wr_addr_q   <= wr_addr_d;
      wr_rgb_q    <= wr_rgb_d;
    end
  end

  assign bus.vram_wr_req  = (state_q == REQ);
  assign bus.vram_wr_addr = wr_addr_q;
  assign bus.vram_wr_data = {8'h00, wr_rgb_q};
  assign busy             = has_entry || (state_q == REQ);
  assign coord_err        = coord_err_q;

endmodule

// File: tb/tb_vdp_super_high_res_writer.sv
// Scoreboard bench: a raster-coordinate model predicts each VRAM write; a monitor pops on ack.
module tb_vdp_super_high_res_writer;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       shr = 1'b1;
  logic       pal = 1'b0;
  logic       set_xy = 1'b0;
  logic [7:0] set_x = 8'd0;
  logic [7:0] set_y = 8'd0;
  logic       busy, coord_err;

  vdp_super_high_res_writer_if bus();

  vdp_super_high_res_writer dut (
    .clk(clk), .reset(reset), .super_high_res(shr), .pal_mode(pal),
    .set_xy(set_xy), .set_x(set_x), .set_y(set_y),
    .bus(bus), .busy(busy), .coord_err(coord_err)
  );

  always #5 clk = ~clk;

  typedef struct { logic [16:0] a; logic [31:0] d; } exp_t;
  exp_t exp_q[$];

  int checks = 0;
  int passed = 0;
  bit ack_mode = 1'b0;
  bit ack_force = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  // Acknowledge source
  initial begin
    bus.vram_wr_ack = 1'b0;
    forever begin
      @(posedge clk); #2;
      bus.vram_wr_ack = (ack_mode && bus.vram_wr_req && ($urandom_range(0, 1) == 1)) || ack_force;
    end
  end

  // Reference model: frame coordinates, address = 2*(y*180+x)
  int mx = 0, my = 0, mh;
  bit merr = 1'b0;
  always @(negedge clk) begin
    mh = pal ? 144 : 120;
    if (reset) begin
      mx = 0; my = 0; merr = 1'b0;
      exp_q.delete();
    end else if (!shr) begin
      chk("ready_low_when_off", bus.pix_ready, 1'b0);
    end else if (set_xy) begin
      chk("ready_low_on_set", bus.pix_ready, 1'b0);
      if (set_x >= 180 || set_y >= mh) begin
        merr = 1'b1; mx = 0; my = 0;
      end else begin
        merr = 1'b0; mx = set_x; my = set_y;
      end
    end else if (bus.pix_valid && bus.pix_ready) begin
      if (!merr) exp_q.push_back(exp_t'{a: 17'(2 * (my * 180 + mx)), d: {8'h00, bus.pix_rgb}});
      mx++;
      if (mx == 180) begin
        mx = 0;
        my = (my >= mh - 1) ? 0 : my + 1;
      end
    end
  end

  // Monitor: request hold/stability and write ordering
  bit req_prev = 1'b0;
  logic [16:0] prev_a;
  logic [31:0] prev_d;
  exp_t e;
  always @(negedge clk) begin
    if (reset) begin
      req_prev = 1'b0;
    end else begin
      if (req_prev) begin
        chk("req_held", bus.vram_wr_req, 1'b1);
        chk("addr_stable", bus.vram_wr_addr, prev_a);
        chk("data_stable", bus.vram_wr_data, prev_d);
      end
      if (bus.vram_wr_req && bus.vram_wr_ack) begin
        if (exp_q.size() == 0) begin
          checks++;
          $display("FAIL unexpected_write: got addr %0h data %0h expected none", bus.vram_wr_addr, bus.vram_wr_data);
        end else begin
          e = exp_q.pop_front();
          chk("wr_addr", bus.vram_wr_addr, e.a);
          chk("wr_data", bus.vram_wr_data, e.d);
        end
        req_prev = 1'b0;
      end else begin
        req_prev = bus.vram_wr_req;
        prev_a   = bus.vram_wr_addr;
        prev_d   = bus.vram_wr_data;
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_pix(input logic [23:0] rgb);
    int n;
    @(posedge clk); #1;
    bus.pix_valid = 1'b1;
    bus.pix_rgb   = rgb;
    for (n = 0; n < 200; n++) begin
      @(negedge clk);
      if (bus.pix_ready) break;
    end
    if (n == 200) begin
      checks++;
      $display("FAIL push_timeout: got no pix_ready expected accept within 200 cycles");
    end
    @(posedge clk); #1;
    bus.pix_valid = 1'b0;
  endtask

  task automatic do_set(input logic [7:0] x, input logic [7:0] y);
    @(posedge clk); #1;
    set_xy = 1'b1; set_x = x; set_y = y;
    @(posedge clk); #1;
    set_xy = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      if (!busy && exp_q.size() == 0) break;
    end
    chk({nm, "_busy"}, busy, 1'b0);
    chk({nm, "_pending"}, exp_q.size(), 0);
  endtask

  task automatic hold_valid(input int want, input int window, output int cnt);
    cnt = 0;
    @(posedge clk); #1;
    bus.pix_valid = 1'b1;
    bus.pix_rgb   = 24'($urandom);
    for (int i = 0; i < window; i++) begin
      @(negedge clk);
      if (bus.pix_ready) cnt++;
      if (cnt == want) break;
      @(posedge clk); #1;
      bus.pix_rgb = 24'($urandom);
    end
    @(posedge clk); #1;
    bus.pix_valid = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  int cnt;
  int exp_burst;
  initial begin
    bus.pix_valid = 1'b0;
    bus.pix_rgb   = 24'd0;
`ifdef SUPER_HIGH_RES_WRITER_FIFO_EN
    exp_burst = 5;
`else
    exp_burst = 1;
`endif
    cyc(3);
    @(negedge clk);
    chk("rst_ready", bus.pix_ready, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_err", coord_err, 1'b0);
    chk("rst_req", bus.vram_wr_req, 1'b0);
    chk("rst_addr", bus.vram_wr_addr, 17'd0);
    chk("rst_data", bus.vram_wr_data, 32'd0);
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", bus.pix_ready, 1'b1);

    // single pixel at origin and its latency
    push_pix(24'h112233);
    @(negedge clk);
    chk("lat_early", bus.vram_wr_req, 1'b0);
    @(negedge clk);
    chk("lat_req", bus.vram_wr_req, 1'b1);
    chk("lat_addr", bus.vram_wr_addr, 17'd0);
    chk("lat_data", bus.vram_wr_data, 32'h00112233);
    ack_mode = 1'b1;
    wait_idle("first");

    // row wrap, frame wrap (NTSC with set_xy colliding with a pixel), frame wrap PAL
    do_set(8'd179, 8'd5);
    push_pix(24'($urandom)); push_pix(24'($urandom));
    wait_idle("row_wrap");
    @(posedge clk); #1;
    set_xy = 1'b1; set_x = 8'd179; set_y = 8'd119;
    bus.pix_valid = 1'b1; bus.pix_rgb = 24'hABCDEF;
    @(posedge clk); #1 set_xy = 1'b0;
    @(negedge clk); chk("ready_after_set", bus.pix_ready, 1'b1);
    @(posedge clk); #1 bus.pix_valid = 1'b0;
    push_pix(24'($urandom));
    wait_idle("ntsc_wrap");
    pal = 1'b1;
    do_set(8'd179, 8'd143);
    @(negedge clk); chk("pal_set_ok", coord_err, 1'b0);
    push_pix(24'($urandom)); push_pix(24'($urandom));
    wait_idle("pal_wrap");
    pal = 1'b0;

    // back-pressure with ack withheld
    ack_mode = 1'b0;
    hold_valid(6, 12, cnt);
    chk("burst_accepted", cnt, exp_burst);
    @(negedge clk);
    chk("burst_ready_low", bus.pix_ready, 1'b0);
    chk("burst_busy", busy, 1'b1);
    ack_mode = 1'b1;
    wait_idle("burst");

    // coordinate errors
    do_set(8'd200, 8'd0);
    @(negedge clk); chk("err_set", coord_err, 1'b1);
    push_pix(24'h010203); push_pix(24'h040506); push_pix(24'h070809);
    cyc(3);
    @(negedge clk);
    chk("err_no_req", bus.vram_wr_req, 1'b0);
    chk("err_no_busy", busy, 1'b0);
    do_set(8'd0, 8'd1);
    @(negedge clk); chk("err_clear", coord_err, 1'b0);
    push_pix(24'h445566);
    wait_idle("err_recover");
    do_set(8'd0, 8'd130);
    @(negedge clk); chk("err_ntsc_y", coord_err, 1'b1);
    do_set(8'd7, 8'd3);
    @(negedge clk); chk("err_clear2", coord_err, 1'b0);

    // mode drop while a write is outstanding
    ack_mode = 1'b0;
    hold_valid(3, 8, cnt);
    chk("flush_fill", cnt, (exp_burst == 5) ? 3 : 1);
    @(posedge clk); #1 shr = 1'b0;
    while (exp_q.size() > 1) void'(exp_q.pop_back());
    @(negedge clk);
    chk("flush_ready", bus.pix_ready, 1'b0);
    chk("flush_req_kept", bus.vram_wr_req, 1'b1);
    do_set(8'd10, 8'd10);
    cyc(3);
    @(negedge clk); chk("flush_req_held", bus.vram_wr_req, 1'b1);
    ack_mode = 1'b1;
    wait_idle("flush");
    cyc(10);
    @(negedge clk);
    chk("flush_quiet", bus.vram_wr_req, 1'b0);
    chk("flush_err_held", coord_err, 1'b0);
    @(posedge clk); #1 shr = 1'b1;
    push_pix(24'h778899);
    wait_idle("resume");

    // reset mid-request, late ack ignored
    ack_mode = 1'b0;
    push_pix(24'h123456);
    cyc(2);
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0; ack_force = 1'b1;
    @(negedge clk);
    chk("rst_mid_req", bus.vram_wr_req, 1'b0);
    chk("rst_mid_busy", busy, 1'b0);
    chk("rst_mid_ready", bus.pix_ready, 1'b1);
    @(posedge clk); #1 ack_force = 1'b0;
    cyc(3);
    @(negedge clk);
    chk("late_ack_idle", bus.vram_wr_req, 1'b0);
    ack_mode = 1'b1;
    push_pix(24'h00FF00);
    wait_idle("post_rst");

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      @(posedge clk); #1;
      bus.pix_valid = ($urandom_range(0, 9) < 6);
      bus.pix_rgb   = 24'($urandom);
      set_xy = ($urandom_range(0, 15) == 0);
      set_x  = 8'($urandom_range(0, 199));
      set_y  = 8'($urandom_range(0, 159));
      if ($urandom_range(0, 99) == 0) pal = ~pal;
      if ($urandom_range(0, 7) == 0) begin
        set_x = 8'd179;
        set_y = pal ? 8'd143 : 8'd119;
      end
    end
    @(posedge clk); #1;
    bus.pix_valid = 1'b0; set_xy = 1'b0;
    wait_idle("random");

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
